// File: rtl/servo_pkg.sv
// Shared widths, constants and FSM state type for the steering-servo PWM generator.
package servo_pkg;

  localparam int W_FRAME = 21;
  localparam int W_PULSE = 18;
  localparam int W_Y     = 11;

  localparam int unsigned     CENTER_TICKS = 150_000;
  localparam logic [W_Y-1:0] Y_MAX        = 11'd1023;

  typedef enum logic [1:0] {LOAD, HIGH, LOW} servo_state_t;

endpackage

// File: rtl/servo_in_filter.sv
// Brings the joystick word across with a 2-FF synchronizer per bit and accepts it only
// after it has been seen unchanged for STABLE_CYCLES consecutive samples.
module servo_in_filter
  import servo_pkg::*;
#(
  parameter int unsigned CENTER        = 512,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W_Y-1:0] y_val,
  output logic [W_Y-1:0] y_filt,
  output logic           y_upd
);

  localparam int W_CNT = $clog2(STABLE_CYCLES + 1);
  localparam logic [W_CNT-1:0] CNT_ACC = W_CNT'(STABLE_CYCLES - 1);
  localparam logic [W_CNT-1:0] CNT_SAT = W_CNT'(STABLE_CYCLES);

  logic [W_Y-1:0]   sync_1, sync_2, y_prev;
  logic [W_CNT-1:0] stab_cnt;
  logic             same, accept;

  assign same   = (sync_2 == y_prev);
  assign accept = same && (stab_cnt == CNT_ACC);

  // The count saturates past the accept point so a held word is accepted only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1   <= W_Y'(CENTER);
      sync_2   <= W_Y'(CENTER);
      y_prev   <= W_Y'(CENTER);
      stab_cnt <= '0;
      y_filt   <= W_Y'(CENTER);
      y_upd    <= 1'b0;
    end else begin
      sync_1 <= y_val;
      sync_2 <= sync_1;
      y_prev <= sync_2;
      if (!same)                    stab_cnt <= '0;
      else if (stab_cnt != CNT_SAT) stab_cnt <= stab_cnt + 1'b1;
      y_upd <= accept;
      if (accept) y_filt <= sync_2;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: filtered joystick word -> clamp/dead zone -> pulse width -> framed PWM.
// Optional build macro SERVO_SLEW_EN limits the pulse-width change per frame to SLEW_TICKS.
//
// state | meaning
// LOAD  | frame counter == 0; frame_start, latch new pulse width and decide on a pulse
// HIGH  | pwm driven high until the counter reaches pulse_ticks
// LOW   | pwm low until the counter wraps
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned PERIOD_TICKS  = CLK_HZ / 50,
  parameter int unsigned MIN_TICKS     = 100_000,
  parameter int unsigned SPAN_TICKS    = 100_000,
  parameter int unsigned CENTER        = 512,
  parameter int unsigned DEADZONE      = 16,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SLEW_TICKS    = 2_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_Y-1:0]     y_val,
  input  logic               enable,
  output logic               pwm,
  output logic [W_PULSE-1:0] pulse_ticks,
  output logic               frame_start
);

  localparam logic [W_FRAME-1:0] LAST_CNT  = W_FRAME'(PERIOD_TICKS - 1);
  localparam logic [W_Y-1:0]     DZ_LO     = W_Y'(CENTER - DEADZONE);
  localparam logic [W_Y-1:0]     DZ_HI     = W_Y'(CENTER + DEADZONE);
  localparam logic [W_PULSE-1:0] CTR_TICKS = W_PULSE'(MIN_TICKS + ((CENTER * SPAN_TICKS) >> 10));
  localparam int W_S = W_PULSE + 2;

`ifdef SERVO_SLEW_EN
  localparam int unsigned SLEW_LIM = SLEW_TICKS;
`else
  // A step limit at least as large as the full pulse range never engages: target passes straight through.
  localparam int unsigned SLEW_LIM = (SLEW_TICKS > (1 << W_PULSE)) ? SLEW_TICKS : (1 << W_PULSE);
`endif

  logic [W_Y-1:0]     y_filt, y_cond, y_s1;
  logic               y_upd, s1_vld;
  logic [31:0]        prod;
  logic [W_PULSE-1:0] target, pulse_next;
  logic [W_S-1:0]     up_lim, dn_lim;
  logic [W_FRAME-1:0] cnt;
  servo_state_t       state, next_state;

  servo_in_filter #(.CENTER(CENTER), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .y_val  (y_val),
    .y_filt (y_filt),
    .y_upd  (y_upd)
  );

  always_comb begin
    y_cond = (y_filt > Y_MAX) ? Y_MAX : y_filt;
    if (y_cond >= DZ_LO && y_cond <= DZ_HI) y_cond = W_Y'(CENTER);
  end

  assign prod = 32'(y_s1) * SPAN_TICKS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_s1   <= W_Y'(CENTER);
      s1_vld <= 1'b0;
      target <= CTR_TICKS;
    end else begin
      s1_vld <= y_upd;
      if (y_upd)  y_s1   <= y_cond;
      if (s1_vld) target <= W_PULSE'(MIN_TICKS + (prod >> 10));
    end
  end

  always_comb begin
    up_lim     = {2'b00, pulse_ticks} + W_S'(SLEW_LIM);
    dn_lim     = {2'b00, target} + W_S'(SLEW_LIM);
    pulse_next = target;
    if ({2'b00, target} > up_lim)           pulse_next = W_PULSE'(up_lim);
    else if ({2'b00, pulse_ticks} > dn_lim) pulse_next = pulse_ticks - W_PULSE'(SLEW_LIM);
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD: next_state = enable ? HIGH : LOW;
      HIGH: begin
        if (cnt == LAST_CNT)                                            next_state = LOAD;
        else if (cnt >= {{(W_FRAME-W_PULSE){1'b0}}, pulse_ticks})       next_state = LOW;
      end
      LOW:  if (cnt == LAST_CNT) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // pwm follows the next state so its high time spans counter values 1..pulse_ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      cnt         <= '0;
      pwm         <= 1'b0;
      pulse_ticks <= CTR_TICKS;
    end else begin
      state <= next_state;
      cnt   <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      pwm   <= (next_state == HIGH);
      if (state == LOAD) pulse_ticks <= pulse_next;
    end
  end

  assign frame_start = rst & (state == LOAD);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen with shortened frame parameters and a frame-level reference model.
module tb_servo_pwm_gen;

  localparam int PERIOD  = 2048;
  localparam int MIN     = 400;
  localparam int SPAN    = 1200;
  localparam int CEN     = 512;
  localparam int DZ      = 16;
  localparam int STAB    = 4;
  localparam int SLEW    = 100;
  localparam int NFRAMES = 28;
  localparam int NDIR    = 9;
  localparam int CTR     = MIN + (CEN * SPAN) / 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] y_val = 11'd512;
  logic        enable = 1'b1;
  logic        pwm;
  logic [17:0] pulse_ticks;
  logic        frame_start;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_HZ(100_000_000), .PERIOD_TICKS(PERIOD), .MIN_TICKS(MIN), .SPAN_TICKS(SPAN),
    .CENTER(CEN), .DEADZONE(DZ), .STABLE_CYCLES(STAB), .SLEW_TICKS(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .y_val(y_val), .enable(enable),
    .pwm(pwm), .pulse_ticks(pulse_ticks), .frame_start(frame_start)
  );

  typedef struct {int pt; int hi;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int y_model  = 512;
  int pm       = CTR;

  // directed frames: act 0 = stable word, 1 = noise burst across the boundary, 2 = set enable
  int d_act [NDIR] = '{0, 0, 0, 0, 0, 1, 0, 2, 2};
  int d_y   [NDIR] = '{1023, 0, 520, 529, 2047, 0, 700, 0, 1};
  int d_p   [NDIR] = '{700, 100, 1200, 40, 1500, 0, 60, 300, 900};

  function automatic int width_of(int y);
    int yc, d;
    yc = (y > 1023) ? 1023 : y;
    d  = yc - CEN;
    if (d < 0) d = -d;
    if (d <= DZ) yc = CEN;
    return MIN + (yc * SPAN) / 1024;
  endfunction

  function automatic int step_to(int cur, int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt - cur > SLEW) return cur + SLEW;
    if (cur - tgt > SLEW) return cur - SLEW;
`endif
    return tgt;
  endfunction

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_fs(int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Called on the negedge of a LOAD cycle; returns at the negedge of the next LOAD cycle.
  task automatic measure(output int pt, output int hi, output int len, output bit seen);
    @(negedge clk);
    pt   = int'(pulse_ticks);
    hi   = int'(pwm);
    len  = 2;
    seen = 1'b0;
    while (len <= PERIOD + 8) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
      hi += int'(pwm);
      len++;
    end
  endtask

  task automatic drive();
    bit seen;
    int pos, act, yv, p, a, b, r;
    wait_fs(16, seen);
    for (int k = 0; k < NFRAMES; k++) begin
      pos = 0;
      if (k < NDIR) begin
        act = d_act[k]; yv = d_y[k]; p = d_p[k];
        a = 300; b = 700;
      end else begin
        act = $urandom_range(0, 3);
        r   = $urandom_range(0, 5);
        yv  = (r == 0) ? 2047 : (r == 1) ? 0 :
              (r == 2) ? CEN - DZ + $urandom_range(0, 2 * DZ) : $urandom_range(0, 2047);
        p   = $urandom_range(2, PERIOD - 30);
        a   = $urandom_range(0, 1023);
        b   = (a + 300) % 1024;
        if (act == 2) yv = ($urandom_range(0, 2) != 0) ? 1 : 0;
      end
      case (act)
        0: begin
          while (pos < p) begin @(negedge clk); pos++; end
          y_val   = 11'(yv);
          y_model = yv;
        end
        1: begin
          while (pos < PERIOD - 100) begin @(negedge clk); pos++; end
          while (pos < PERIOD - 1) begin
            y_val = 11'(((pos / 2) % 2 == 1) ? a : b);
            @(negedge clk);
            pos++;
          end
          y_val = 11'(y_model);
        end
        2: begin
          while (pos < p) begin @(negedge clk); pos++; end
          enable = (yv != 0);
        end
        default: ;
      endcase
      while (pos < PERIOD - 1) begin @(negedge clk); pos++; end
      pm = step_to(pm, width_of(y_model));
      exp_q.push_back('{pm, enable ? pm : 0});
      @(negedge clk);
    end
  endtask

  task automatic monitor();
    bit   seen;
    exp_t e;
    int   pt, hi, len;
    wait_fs(16, seen);
    check("first_frame_start", int'(seen), 1);
    if (!seen) return;
    for (int k = 0; k < NFRAMES; k++) begin
      measure(pt, hi, len, seen);
      check("frame_len", seen ? len : -1, PERIOD);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: frame %0d has no expected entry", k);
      end else begin
        e = exp_q.pop_front();
        check("pulse_ticks", pt, e.pt);
        check("high_cycles", hi, e.hi);
      end
      if (!seen) break;
    end
  endtask

  initial begin
    bit seen;
    int pt, hi, len;
    repeat (4) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_pulse_ticks", int'(pulse_ticks), CTR);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back('{CTR, CTR});
    fork
      drive();
      monitor();
    join

    // asynchronous reset in the middle of a pulse
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (pwm) begin seen = 1'b1; break; end
    end
    check("pulse_before_reset", int'(seen), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_frame_start", int'(frame_start), 0);
    check("async_rst_pulse_ticks", int'(pulse_ticks), CTR);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("restart_frame_start", int'(frame_start), 1);
    measure(pt, hi, len, seen);
    check("restart_pulse_ticks", pt, CTR);
    check("restart_high_cycles", hi, CTR);
    check("restart_frame_len", seen ? len : -1, PERIOD);
    if (seen) begin
      measure(pt, hi, len, seen);
      check("post_restart_pulse_ticks", pt, step_to(CTR, width_of(y_model)));
      check("post_restart_high_cycles", hi, step_to(CTR, width_of(y_model)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
